// File: rtl/vga_timing_gen_if.sv
// Purpose: video raster bus between the timing generator and the drawing stages.
// Latency: n/a (signal bundle only).
// Backpressure: none; ce paces the raster and resync restarts it.
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          ce;
  logic          resync;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hblnk;
  logic          vblnk;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic [15:0]   frame_cnt;

  // Generator side: takes pacing/restart controls, drives the raster.
  modport master (
    input  ce, resync,
    output hcount, vcount, hblnk, vblnk, hsync, vsync, de,
           line_start, frame_start, frame_cnt
  );

  // Consumer side: paces the raster and observes it.
  modport slave (
    output ce, resync,
    input  hcount, vcount, hblnk, vblnk, hsync, vsync, de,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA/XGA raster timing generator (counts, blanking, sync, de, strobes).
// Latency: all outputs registered; flags decoded from next-state counts, so they align with hcount/vcount.
// Backpressure: ce=0 freezes every output (strobes forced low); resync during ce=0 is held until ce=1.
// Optional: define VGA_TIMING_FRAME_CNT_EN to build the completed-frame counter on frame_cnt.
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_gen_if.master    vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Reject configurations the counters cannot represent or that collapse a timing region.
  if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range 2**CW");
  end
  if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic [CW-1:0] hcount_q, vcount_q;
  logic          hblnk_q, vblnk_q, hsync_q, vsync_q, de_q;
  logic          line_start_q, frame_start_q;
  logic          resync_pend_q;

  logic [CW-1:0] h_nxt, v_nxt;
  logic          ls_nxt, fs_nxt;
  logic          do_resync;
  logic          hblnk_nxt, vblnk_nxt, hsync_nxt, vsync_nxt, de_nxt;

  // Next raster position and strobes; holds position when ce is low.
  always_comb begin
    h_nxt     = hcount_q;
    v_nxt     = vcount_q;
    ls_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    do_resync = vif.resync | resync_pend_q;
    if (vif.ce) begin
      if (do_resync) begin
        h_nxt  = '0;
        v_nxt  = '0;
        ls_nxt = 1'b1;
        fs_nxt = 1'b1;
      end else if (hcount_q == H_LAST) begin
        h_nxt  = '0;
        ls_nxt = 1'b1;
        if (vcount_q == V_LAST) begin
          v_nxt  = '0;
          fs_nxt = 1'b1;
        end else begin
          v_nxt = vcount_q + 1'b1;
        end
      end else begin
        h_nxt = hcount_q + 1'b1;
      end
    end
  end

  // Decode blanking/sync/de from the next position so they register alongside the counts.
  always_comb begin
    hblnk_nxt = (h_nxt >= H_ACT_C);
    vblnk_nxt = (v_nxt >= V_ACT_C);
    hsync_nxt = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
    vsync_nxt = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
    de_nxt    = ~hblnk_nxt & ~vblnk_nxt;
  end

  // Raster state register; a resync seen while ce is low waits here for the next ce cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      resync_pend_q <= 1'b0;
    end else begin
      hcount_q      <= h_nxt;
      vcount_q      <= v_nxt;
      hblnk_q       <= hblnk_nxt;
      vblnk_q       <= vblnk_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      de_q          <= de_nxt;
      line_start_q  <= ls_nxt;
      frame_start_q <= fs_nxt;
      resync_pend_q <= vif.ce ? 1'b0 : do_resync;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count natural frame wraps only; a resync restart alone does not complete a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (vif.ce && (hcount_q == H_LAST) && (vcount_q == V_LAST)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vif.frame_cnt = frame_cnt_q;
`else
  assign vif.frame_cnt = 16'd0;
`endif

  assign vif.hcount      = hcount_q;
  assign vif.vcount      = vcount_q;
  assign vif.hblnk       = hblnk_q;
  assign vif.vblnk       = vblnk_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.de          = de_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule
